// File: rtl/seq_divider_16bit_pkg.sv
// seq_divider_16bit_pkg: shared width, FSM encoding and constants for the divider.
// Contents:
//   WIDTH         operand/result width (only 16 is supported)
//   state_t       FSM states IDLE/BUSY/DONE
//   DIV0_QUOTIENT quotient reported for a zero divisor
//   ITER_LAST     value of the iteration counter on the final iteration
package seq_divider_16bit_pkg;
    localparam int WIDTH = 16;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam logic [WIDTH-1:0] DIV0_QUOTIENT = 16'hFFFF;
    localparam logic [3:0] ITER_LAST = 4'd15;
endpackage

// File: rtl/seq_divider_16bit_if.sv
// seq_divider_16bit_if: start/done handshake and operand/result bus of the divider.
// Signals:
//   start        request pulse from the controller
//   dividend     unsigned dividend
//   divisor      unsigned divisor
//   busy         high while the divider iterates
//   done         one-cycle result-valid pulse
//   quotient     result quotient
//   remainder    result remainder
//   div_by_zero  set with done when the divisor was zero
// Modports: master = ALU controller, slave = divider.
interface seq_divider_16bit_if;
    import seq_divider_16bit_pkg::*;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_16bit_cla.sv
// carry_look_ahead_16bit: 16-bit carry-lookahead adder/subtractor.
// Ports:
//   a, b  16-bit operands
//   mode  0 = add, 1 = subtract (b is inverted; pair with cin=1)
//   cin   carry in
//   sum   16-bit result
//   cout  carry out (for subtraction: 1 means a >= b)
module carry_look_ahead_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        mode,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [15:0] bb, g, p, c;
    logic        blk, carry, gg, pp;
    assign bb = b ^ {16{mode}};
    assign g  = a & bb;
    assign p  = a ^ bb;
    // Four 4-bit groups: carries ripple inside a group, group generate/propagate
    // terms carry across groups.
    always_comb begin
        c     = '0;
        blk   = cin;
        carry = 1'b0;
        gg    = 1'b0;
        pp    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            carry = blk;
            gg    = 1'b0;
            pp    = 1'b1;
            for (int j = 0; j < 4; j++) begin
                c[4*k+j] = carry;
                carry    = g[4*k+j] | (p[4*k+j] & carry);
                gg       = g[4*k+j] | (p[4*k+j] & gg);
                pp       = pp & p[4*k+j];
            end
            blk = gg | (pp & blk);
        end
    end
    assign sum  = p ^ c;
    assign cout = blk;
endmodule

// File: rtl/seq_divider_16bit.sv
// seq_divider_16bit: iterative 16/16 unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    seq_divider_16bit_if.slave: start/operands in, busy/done/results out
module seq_divider_16bit
    import seq_divider_16bit_pkg::*;
(
    input logic clk,
    input logic rst_n,
    seq_divider_16bit_if.slave bus
);
    state_t           state, next_state;
    logic [WIDTH-1:0] r, q, d, t, r_next, q_next;
    logic [WIDTH:0]   s;
    logic [3:0]       count;
    logic             c, take, accept, zero_div;

    // Shifted partial remainder; its top bit set means it already exceeds any divisor.
    assign s        = {r, q[WIDTH-1]};
    assign take     = s[WIDTH] | c;
    assign r_next   = take ? t : s[WIDTH-1:0];
    assign q_next   = {q[WIDTH-2:0], take};
    assign accept   = (state == IDLE) && bus.start;
    assign zero_div = bus.divisor == '0;

    carry_look_ahead_16bit u_sub (
        .a    (s[WIDTH-1:0]),
        .b    (d),
        .mode (1'b1),
        .cin  (1'b1),
        .sum  (t),
        .cout (c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = (state == IDLE) ? (bus.start ? (zero_div ? DONE : BUSY) : IDLE)
                   : (state == BUSY) ? ((count == ITER_LAST) ? DONE : BUSY)
                   : IDLE;
    end

    always_comb begin
        bus.busy = state == BUSY;
        bus.done = state == DONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r               <= '0;
            q               <= '0;
            d               <= '0;
            count           <= '0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else if (accept && zero_div) begin
            bus.quotient    <= DIV0_QUOTIENT;
            bus.remainder   <= bus.dividend;
            bus.div_by_zero <= 1'b1;
        end else if (accept) begin
            r               <= '0;
            q               <= bus.dividend;
            d               <= bus.divisor;
            count           <= '0;
            bus.div_by_zero <= 1'b0;
        end else if (state == BUSY) begin
            r     <= r_next;
            q     <= q_next;
            count <= count + 4'd1;
            if (count == ITER_LAST) begin
                bus.quotient  <= q_next;
                bus.remainder <= r_next;
            end
        end
    end
endmodule
